// File: rtl/program_fetch_4.sv
// Small generic FIFO used as the fetch queue; head is exposed combinationally from storage.
// Latency: a push is visible at the head on the edge after it is written.
// Backpressure: pushes into a full queue are dropped unless a pop frees a slot that cycle.
module fetch_fifo #(
    parameter int  W     = 8,
    parameter int  DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] occ
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop   = pop && (occ != '0);
    assign do_push  = push_vld && ((occ != CW'(DEPTH)) || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Contents are left in place; with occ at zero they are never presented as valid.
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: ;
            endcase
        end
    end
endmodule

// Instruction fetch: drives the registered 4-byte ROM and streams its words as valid/ready instructions.
// Latency: two edges from issue to instr_valid; first target instruction valid three cycles after a jump.
// Backpressure: 2-entry queue; issue stalls while queued plus in-flight words would exceed its depth.
module program_fetch_4 #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_address,
    input  logic [7:0]  mem_in0,
    input  logic [7:0]  mem_in1,
    input  logic [7:0]  mem_in2,
    input  logic [7:0]  mem_in3,
    input  logic        halt,
    input  logic        jump_valid,
    input  logic [15:0] jump_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [15:0] instr_pc
);
    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic [15:0] addr_q;
    logic [15:0] rd_pc;
    logic        rd_valid;
    fetch_t      push_dat;
    fetch_t      head_dat;
    logic [1:0]  occ;
    logic        pop;
    logic        issue_en;
    logic [2:0]  demand;

    assign mem_address = addr_q;
    assign instr_valid = (occ != 2'd0);
    assign pop         = instr_valid && instr_ready;

    // Words that will occupy the queue after this edge if nothing new is issued.
    assign demand   = {1'b0, occ} + {2'b00, rd_valid} - {2'b00, pop};
    assign issue_en = !halt && !jump_valid && (demand <= 3'd1);

    assign push_dat = {rd_pc, mem_in3, mem_in2, mem_in1, mem_in0};
    assign instr    = head_dat.instr;
    assign instr_pc = head_dat.pc;

    fetch_fifo #(
        .W     ($bits(fetch_t)),
        .DEPTH (2)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst),
        .flush    (jump_valid),
        .push_vld (rd_valid),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .occ      (occ)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= RESET_PC;
            rd_pc    <= 16'h0000;
            rd_valid <= 1'b0;
        end else if (jump_valid) begin
            addr_q   <= jump_target;
            rd_valid <= 1'b0;
        end else if (issue_en) begin
            rd_valid <= 1'b1;
            rd_pc    <= addr_q;
            addr_q   <= addr_q + 16'd4;
        end else begin
            rd_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_program_fetch_4.sv
// Scoreboarded bench for program_fetch_4: directed stream, stall, jump, wrap, halt and reset scenarios.
module tb_program_fetch_4;
    typedef struct {
        logic [15:0] pc;
        logic [31:0] instr;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q [$];
    exp_t exp_b [$];
    exp_t ea;
    exp_t eb;

    logic        clk;
    logic        rst;
    logic [15:0] mem_address;
    logic [7:0]  mem_in0, mem_in1, mem_in2, mem_in3;
    logic        halt;
    logic        jump_valid;
    logic [15:0] jump_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [15:0] instr_pc;

    logic        rst_b;
    logic [15:0] mem_address_b;
    logic [7:0]  mem_b0, mem_b1, mem_b2, mem_b3;
    logic        instr_valid_b;
    logic [31:0] instr_b;
    logic [15:0] instr_pc_b;

    program_fetch_4 #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .mem_address(mem_address),
        .mem_in0(mem_in0), .mem_in1(mem_in1), .mem_in2(mem_in2), .mem_in3(mem_in3),
        .halt(halt), .jump_valid(jump_valid), .jump_target(jump_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    program_fetch_4 #(.RESET_PC(16'h0020)) dut_b (
        .clk(clk), .rst(rst_b), .mem_address(mem_address_b),
        .mem_in0(mem_b0), .mem_in1(mem_b1), .mem_in2(mem_b2), .mem_in3(mem_b3),
        .halt(1'b0), .jump_valid(1'b0), .jump_target(16'h0000),
        .instr_valid(instr_valid_b), .instr_ready(1'b1),
        .instr(instr_b), .instr_pc(instr_pc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM with mem[i] = i & 0xFF.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_in0 <= 8'h00; mem_in1 <= 8'h00; mem_in2 <= 8'h00; mem_in3 <= 8'h00;
        end else begin
            mem_in0 <= mem_address[7:0];
            mem_in1 <= mem_address[7:0] + 8'd1;
            mem_in2 <= mem_address[7:0] + 8'd2;
            mem_in3 <= mem_address[7:0] + 8'd3;
        end
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem_b0 <= 8'h00; mem_b1 <= 8'h00; mem_b2 <= 8'h00; mem_b3 <= 8'h00;
        end else begin
            mem_b0 <= mem_address_b[7:0];
            mem_b1 <= mem_address_b[7:0] + 8'd1;
            mem_b2 <= mem_address_b[7:0] + 8'd2;
            mem_b3 <= mem_address_b[7:0] + 8'd3;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input logic [15:0] pc, input logic [31:0] word);
        exp_t e;
        e.pc = pc;
        e.instr = word;
        exp_q.push_back(e);
    endtask

    task automatic expect_b(input logic [15:0] pc, input logic [31:0] word);
        exp_t e;
        e.pc = pc;
        e.instr = word;
        exp_b.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("no_overflow", {31'd0, (dut.rd_valid && (dut.occ == 2'd2))}, 32'd0);
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_instr: got pc 0x%0h, none expected", instr_pc);
                end else begin
                    ea = exp_q.pop_front();
                    check("stream_pc", {16'd0, instr_pc}, {16'd0, ea.pc});
                    check("stream_instr", instr, ea.instr);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b && instr_valid_b) begin
            if (exp_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr_b: got pc 0x%0h, none expected", instr_pc_b);
            end else begin
                eb = exp_b.pop_front();
                check("b_stream_pc", {16'd0, instr_pc_b}, {16'd0, eb.pc});
                check("b_stream_instr", instr_b, eb.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; rst_b = 1'b0;
        halt = 1'b0; jump_valid = 1'b0; jump_target = 16'h0000; instr_ready = 1'b1;
        repeat (3) tick();
        check("reset_mem_address", {16'd0, mem_address}, 32'h0000);
        check("reset_valid", {31'd0, instr_valid}, 32'd0);
        check("reset_instr", instr, 32'h0);
        check("reset_pc", {16'd0, instr_pc}, 32'h0);

        expect_a(16'h0000, 32'h03020100);
        expect_a(16'h0004, 32'h07060504);
        expect_a(16'h0008, 32'h0B0A0908);
        expect_a(16'h000C, 32'h0F0E0D0C);
        rst = 1'b1;
        tick();
        check("first_edge_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("second_edge_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_pc", {16'd0, instr_pc}, 32'h0004);
            check("stall_instr", instr, 32'h07060504);
            tick();
        end
        instr_ready = 1'b1;
        repeat (3) tick();

        // Fill the queue, then jump while it is full.
        instr_ready = 1'b0;
        tick();
        expect_a(16'h0040, 32'h43424140);
        expect_a(16'h0044, 32'h47464544);
        jump_valid = 1'b1; jump_target = 16'h0040;
        tick();
        jump_valid = 1'b0; instr_ready = 1'b1;
        check("full_jump_gap1", {31'd0, instr_valid}, 32'd0);
        tick();
        check("full_jump_gap2", {31'd0, instr_valid}, 32'd0);
        tick();
        check("full_jump_head", {16'd0, instr_pc}, 32'h0040);
        tick();

        expect_a(16'hFFF8, 32'hFBFAF9F8);
        expect_a(16'hFFFC, 32'hFFFEFDFC);
        expect_a(16'h0000, 32'h03020100);
        expect_a(16'h0004, 32'h07060504);
        expect_a(16'h0008, 32'h0B0A0908);
        jump_valid = 1'b1; jump_target = 16'hFFF8;
        tick();
        jump_valid = 1'b0;
        check("wrap_gap1", {31'd0, instr_valid}, 32'd0);
        tick();
        check("wrap_gap2", {31'd0, instr_valid}, 32'd0);
        repeat (5) tick();

        // Jump in the same cycle pc 8 fires.
        check("fire_jump_head", {16'd0, instr_pc}, 32'h0008);
        expect_a(16'h0100, 32'h03020100);
        expect_a(16'h0104, 32'h07060504);
        expect_a(16'h0108, 32'h0B0A0908);
        jump_valid = 1'b1; jump_target = 16'h0100;
        tick();
        jump_valid = 1'b0;
        check("fire_jump_gap1", {31'd0, instr_valid}, 32'd0);
        tick();
        check("fire_jump_gap2", {31'd0, instr_valid}, 32'd0);
        tick();
        check("fire_jump_target", {16'd0, instr_pc}, 32'h0100);
        tick();

        halt = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            check("halt_drained", {31'd0, instr_valid}, 32'd0);
            check("halt_addr_frozen", {16'd0, mem_address}, 32'h010C);
            tick();
        end
        expect_a(16'h010C, 32'h0F0E0D0C);
        halt = 1'b0;
        tick();
        halt = 1'b1;
        tick();
        check("resume_head", {16'd0, instr_pc}, 32'h010C);
        tick();
        check("resume_drained", {31'd0, instr_valid}, 32'd0);
        check("resume_addr", {16'd0, mem_address}, 32'h0110);

        check("b_reset_address", {16'd0, mem_address_b}, 32'h0020);
        check("b_reset_valid", {31'd0, instr_valid_b}, 32'd0);
        expect_b(16'h0020, 32'h23222120);
        expect_b(16'h0024, 32'h27262524);
        rst_b = 1'b1;
        tick();
        check("b_first_edge_valid", {31'd0, instr_valid_b}, 32'd0);
        repeat (3) tick();
        #2;
        rst_b = 1'b0;
        #1;
        check("b_async_valid", {31'd0, instr_valid_b}, 32'd0);
        check("b_async_instr", instr_b, 32'h0);
        check("b_async_pc", {16'd0, instr_pc_b}, 32'h0);
        check("b_async_address", {16'd0, mem_address_b}, 32'h0020);
        tick();
        expect_b(16'h0020, 32'h23222120);
        rst_b = 1'b1;
        tick();
        check("b_restart_gap", {31'd0, instr_valid_b}, 32'd0);
        tick();
        check("b_restart_pc", {16'd0, instr_pc_b}, 32'h0020);
        tick();
        #2;
        rst_b = 1'b0;
        repeat (2) tick();

        check("main_queue_drained", exp_q.size(), 32'd0);
        check("b_queue_drained", exp_b.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
